// File: rtl/scope_capture_ctrl_if.sv
// Write-port and display handshake between scope_capture_ctrl (master) and the
// sample buffer / VGA read side (slave).
interface scope_capture_ctrl_if #(
    parameter int DATA_W = 16,
    parameter int AW     = 8
);
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [AW-1:0]     rd_base;
    logic              capture_valid;
    logic              frame_done;

    modport master (
        output wr_en, wr_addr, wr_data, rd_base, capture_valid,
        input  frame_done
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_base, capture_valid,
        output frame_done
    );
endinterface

// File: rtl/scope_capture_ctrl.sv
// Oscilloscope trigger/capture sequencer: decimates samples into a circular buffer,
// freezes it after a trigger and re-arms after HOLD_FRAMES frames.
// Optional forced trigger on timeout: define SCOPE_CAPTURE_CTRL_AUTO_TRIG_EN.
module scope_capture_ctrl #(
    parameter int DATA_W       = 16,
    parameter int AW           = 8,
    parameter int PRETRIG      = 32,
    parameter int HOLD_FRAMES  = 2,
    parameter int AUTO_TIMEOUT = 4096
) (
    input  logic                     CLOCK_50,
    input  logic                     reset_n,
    input  logic signed [DATA_W-1:0] signal,
    input  logic signed [DATA_W-1:0] trig_level,
    input  logic                     trig_slope,
    input  logic [7:0]               decim,
    input  logic                     run,
    scope_capture_ctrl_if.master     bus,
    output logic [2:0]               state,
    output logic                     auto_fired
);
    localparam int DEPTH = 2 ** AW;
    localparam int FW    = $clog2(HOLD_FRAMES + 1);

    localparam logic [AW-1:0] FILL_LAST = AW'(PRETRIG - 1);
    localparam logic [AW-1:0] POST_LAST = AW'(DEPTH - PRETRIG - 2);
    localparam logic [AW-1:0] PRE_OFS   = AW'(PRETRIG);
    localparam logic [FW-1:0] HOLD_LAST = FW'(HOLD_FRAMES - 1);

    if (PRETRIG < 1 || PRETRIG > DEPTH - 2) begin : g_bad_pretrig
        $error("scope_capture_ctrl: PRETRIG must lie in 1..DEPTH-2");
    end
    if (HOLD_FRAMES < 1) begin : g_bad_hold
        $error("scope_capture_ctrl: HOLD_FRAMES must be at least 1");
    end
    if (AUTO_TIMEOUT < 1) begin : g_bad_timeout
        $error("scope_capture_ctrl: AUTO_TIMEOUT must be at least 1");
    end

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        ARMED = 3'd2,
        POST  = 3'd3,
        HOLD  = 3'd4
    } state_t;

    state_t                    cur_state;
    logic [7:0]                div_cnt;
    logic [7:0]                decim_l;
    logic [AW-1:0]             ptr;
    logic [AW-1:0]             trig_addr;
    logic [AW-1:0]             fill_cnt;
    logic [AW-1:0]             post_cnt;
    logic [FW-1:0]             frame_cnt;
    logic signed [DATA_W-1:0]  prev;
    logic                      strobe;
    logic                      acquiring;
    logic                      trig_hit;
    logic                      auto_hit;

    assign state     = cur_state;
    assign acquiring = (cur_state == FILL) || (cur_state == ARMED) || (cur_state == POST);
    assign strobe    = (div_cnt == decim_l);
    assign trig_hit  = trig_slope ? ((prev < trig_level) && (signal >= trig_level))
                                  : ((prev > trig_level) && (signal <= trig_level));

`ifdef SCOPE_CAPTURE_CTRL_AUTO_TRIG_EN
    localparam int ACW = $clog2(AUTO_TIMEOUT + 1);
    localparam logic [ACW-1:0] AUTO_LAST = ACW'(AUTO_TIMEOUT - 1);

    logic [ACW-1:0] auto_cnt;
    logic           auto_fired_q;

    assign auto_hit   = (auto_cnt == AUTO_LAST);
    assign auto_fired = auto_fired_q;
`else
    assign auto_hit   = 1'b0;
    assign auto_fired = 1'b0;
`endif

    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            cur_state         <= IDLE;
            div_cnt           <= '0;
            decim_l           <= '0;
            ptr               <= '0;
            trig_addr         <= '0;
            fill_cnt          <= '0;
            post_cnt          <= '0;
            frame_cnt         <= '0;
            prev              <= '0;
            bus.wr_en         <= 1'b0;
            bus.wr_addr       <= '0;
            bus.wr_data       <= '0;
            bus.rd_base       <= '0;
            bus.capture_valid <= 1'b0;
`ifdef SCOPE_CAPTURE_CTRL_AUTO_TRIG_EN
            auto_cnt          <= '0;
            auto_fired_q      <= 1'b0;
`endif
        end else if (!run) begin
            cur_state         <= IDLE;
            bus.wr_en         <= 1'b0;
            bus.capture_valid <= 1'b0;
        end else begin
            bus.wr_en <= 1'b0;

            // Every acquisition strobe is written one cycle later at the current pointer.
            if (acquiring) begin
                div_cnt <= strobe ? 8'd0 : div_cnt + 8'd1;
                if (strobe) begin
                    bus.wr_en   <= 1'b1;
                    bus.wr_addr <= ptr;
                    bus.wr_data <= signal;
                    ptr         <= ptr + AW'(1);
                    prev        <= signal;
                end
            end

            case (cur_state)
                IDLE: begin
                    cur_state         <= FILL;
                    decim_l           <= decim;
                    div_cnt           <= '0;
                    ptr               <= '0;
                    fill_cnt          <= '0;
                    bus.capture_valid <= 1'b0;
                end
                FILL: begin
                    if (strobe) begin
                        if (fill_cnt == FILL_LAST) begin
                            cur_state <= ARMED;
`ifdef SCOPE_CAPTURE_CTRL_AUTO_TRIG_EN
                            auto_cnt  <= '0;
`endif
                        end else begin
                            fill_cnt <= fill_cnt + AW'(1);
                        end
                    end
                end
                ARMED: begin
                    if (strobe) begin
                        if (trig_hit || auto_hit) begin
                            cur_state    <= POST;
                            trig_addr    <= ptr;
                            post_cnt     <= '0;
`ifdef SCOPE_CAPTURE_CTRL_AUTO_TRIG_EN
                            auto_fired_q <= !trig_hit;
                        end else begin
                            auto_cnt     <= auto_cnt + ACW'(1);
`endif
                        end
                    end
                end
                POST: begin
                    if (strobe) begin
                        if (post_cnt == POST_LAST) begin
                            cur_state         <= HOLD;
                            bus.capture_valid <= 1'b1;
                            bus.rd_base       <= trig_addr - PRE_OFS;
                            frame_cnt         <= '0;
                        end else begin
                            post_cnt <= post_cnt + AW'(1);
                        end
                    end
                end
                HOLD: begin
                    // The pointer keeps running across re-arms; only the fill count restarts.
                    if (bus.frame_done) begin
                        if (frame_cnt == HOLD_LAST) begin
                            cur_state         <= FILL;
                            bus.capture_valid <= 1'b0;
                            fill_cnt          <= '0;
                        end else begin
                            frame_cnt <= frame_cnt + FW'(1);
                        end
                    end
                end
                default: cur_state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/scope_capture_ctrl.md
Name: scope_capture_ctrl

Overview:
- Trigger and capture sequencer for the oscilloscope sample buffer.
- Decimates the 16-bit input stream and writes it into a DEPTH-entry circular buffer through a write port.
- Detects a level/slope trigger, stops writing after a fixed post-trigger count, then freezes the buffer for display.
- Publishes the display start address and re-arms after HOLD_FRAMES vertical-sync pulses from the VGA side.

Parameters:
- DATA_W, 16, sample width (two's complement).
- AW, 8, buffer address width; DEPTH = 2**AW.
- PRETRIG, 32, samples kept before the trigger point; legal range 1..DEPTH-2.
- HOLD_FRAMES, 2, frame_done pulses spent in HOLD before re-arming; minimum 1.
- AUTO_TIMEOUT, 4096, sample strobes before forced trigger (used only with the optional feature).

Ports:
- CLOCK_50, in, 1, system clock; all logic on posedge.
- reset_n, in, 1, synchronous active-low reset.
- signal, in, DATA_W, input sample (signed).
- trig_level, in, DATA_W, signed trigger threshold.
- trig_slope, in, 1, 1 = rising crossing, 0 = falling crossing.
- decim, in, 8, sample strobe every decim+1 clocks.
- run, in, 1, 1 = acquire; 0 = return to IDLE.
- frame_done, in, 1, one-cycle pulse per display frame (VS, synchronous to CLOCK_50).
- wr_en, out, 1, buffer write strobe.
- wr_addr, out, AW, buffer write address.
- wr_data, out, DATA_W, buffer write data.
- rd_base, out, AW, buffer address of the oldest displayed sample.
- capture_valid, out, 1, 1 = buffer frozen and rd_base valid.
- state, out, 3, current state code.
- auto_fired, out, 1, last capture was forced (always 0 without the optional feature).

Behaviour:
- Reset (reset_n=0 at a clock edge): state=IDLE, wr_en=0, wr_addr=0, wr_data=0, rd_base=0, capture_valid=0, auto_fired=0, all counters cleared, prev sample=0.
- Strobe generator:
  - Divider counts 0..decim_l.
  - strobe=1 when the divider equals decim_l.
  - decim_l is latched on IDLE->FILL.
  - decim changes mid-capture are ignored.
- On each strobe in FILL, ARMED or POST:
  - wr_en=1 on the next cycle, with wr_data=signal and wr_addr=ptr.
  - ptr then increments mod DEPTH, wrapping 255->0.
  - One-cycle write latency from the strobe; wr_en=0 otherwise.
- Trigger condition, evaluated on strobes only, signed compare:
  - rising: prev<trig_level && signal>=trig_level.
  - falling: prev>trig_level && signal<=trig_level.
  - prev updates on every strobe.
- States: IDLE=0, FILL=1, ARMED=2, POST=3, HOLD=4.
- IDLE:
  - run=1 -> FILL.
  - Clear ptr, pre-trigger count and capture_valid.
- FILL:
  - Write strobes until PRETRIG samples are stored, then -> ARMED.
  - Triggers during FILL are ignored.
  - Ensures rd_base never points at unwritten data.
- ARMED:
  - Trigger -> POST; trig_addr = address written for the trigger sample.
  - The trigger sample itself is written.
- POST:
  - After DEPTH-PRETRIG-1 further writes, -> HOLD.
  - rd_base = (trig_addr - PRETRIG) mod DEPTH, AW-bit wrap.
  - capture_valid=1 from the cycle HOLD is entered.
- HOLD:
  - No writes.
  - Count frame_done pulses; on the HOLD_FRAMES-th pulse -> FILL.
  - capture_valid drops in that same cycle.
  - rd_base is held at its last value.
- run=0 in any state:
  - -> IDLE next cycle, aborting any write in flight.
  - capture_valid=0 on that same next cycle.
- Simultaneous events:
  - run=0 takes priority over trigger, end of post count and frame_done.
  - A trigger on the strobe that completes FILL is ignored.
  - frame_done outside HOLD is ignored.
- reset_n has priority over everything.

Optional Feature:
- Macro: SCOPE_CAPTURE_CTRL_AUTO_TRIG_EN.
- Defined:
  - In ARMED, count strobes.
  - At AUTO_TIMEOUT strobes with no trigger, force a trigger on the current strobe and set auto_fired=1.
  - A real trigger clears auto_fired.
  - The counter clears on entering ARMED.
- Undefined:
  - ARMED waits indefinitely.
  - auto_fired is tied to 0.
  - No timeout counter is synthesized.

Test Plan:
- Reset: hold reset_n=0 for 3 clocks while run=1 -> all outputs 0 and state=0; FILL is entered 1 clock after reset_n=1.
- Decimation: decim=3, run=1 -> wr_en pulses every 4 clocks with wr_addr 0,1,2,...; changing decim to 0 mid-FILL leaves the spacing at 4.
- Rising trigger: ramp signal -100..+100 step 1 per strobe, trig_level=0, PRETRIG=32, decim=0 -> trigger at sample 0 (wr_addr 100) and exactly 223 more writes; capture_valid=1 with rd_base=68.
- Wrap and falling slope: trigger placed at wr_addr=10 -> rd_base=234 (10-32 mod 256); no writes during HOLD.
- Re-arm and abort:
  - In HOLD, two frame_done pulses (HOLD_FRAMES=2) -> FILL and capture_valid=0 on the 2nd pulse; frame_done in ARMED has no effect.
  - run=0 during POST -> IDLE next clock with wr_en=0.
- Auto trigger (macro defined, AUTO_TIMEOUT=16): constant signal in ARMED -> forced trigger on the 16th strobe and auto_fired=1; the next real trigger clears auto_fired.
